truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises the 4-input breadboard logic block (inputs w,x,y,z; outputs r6..r9) in hardware. On start it drives all 16 input combinations in order, waits a programmable settle time, samples the four outputs and compares them against golden truth-table vectors. It reports pass/fail, a mismatch count, per-function failure flags and the first failing index. It replaces the open-loop testbench loop with a synthesizable self-checking controller.

Parameters:
SETTLE_CYCLES, 2, cycles {w,x,y,z} is held before sampling; legal range 1..15
EXP6, 16'h212E, golden f6; bit i = expected r6 for i = {w,x,y,z}
EXP7, 16'h1668, golden f7
EXP8, 16'h8888, golden f8 (y&z)
EXP9, 16'h6996, golden f9

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  cancel sweep in progress
w  out  1  drive to breadboard, idx[3]
x  out  1  idx[2]
y  out  1  idx[1]
z  out  1  idx[0]
r6  in  1  breadboard output f6
r7  in  1  f7
r8  in  1  f8
r9  in  1  f9
busy  out  1  high in SETTLE/SAMPLE
done  out  1  level; high in DONE until next start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  5  vectors with any mismatch, 0..16
fail_mask  out  4  sticky per-function mismatch; bit0=r6 .. bit3=r9
first_fail_idx  out  4  index of first mismatching vector
first_fail_valid  out  1  first_fail_idx holds a captured value

Behaviour:
- Reset (async, immediate): state IDLE; w,x,y,z=0; busy, done, pass, first_fail_valid=0; err_count=0; fail_mask=0; first_fail_idx=0; idx=0; settle counter=0.
- {w,x,y,z} are registered outputs equal to idx.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start: idx<=0, settle cnt<=SETTLE_CYCLES-1, clear err_count, fail_mask, first_fail_*, pass, done; -> SETTLE. busy asserts the cycle after start.
- SETTLE: cnt decrements each cycle; at cnt==0 -> SAMPLE. Each idx value is held exactly SETTLE_CYCLES cycles before the sample cycle.
- SAMPLE (one cycle): mism[k] = r(6+k) XOR EXP(6+k)[idx]. If mism!=0: err_count+=1; fail_mask|=mism; if !first_fail_valid, capture idx, set first_fail_valid. If idx==15 -> DONE; else idx<=idx+1, cnt reload, -> SETTLE.
- Per vector SETTLE_CYCLES+1 cycles; full sweep 16*(SETTLE_CYCLES+1) cycles from start-accept edge to DONE entry (48 at default).
- Terminal detection is the explicit compare idx==15; idx is 4 bits and never wraps or reaches 16. err_count is 5 bits so 16 is representable, no saturation needed.
- DONE: busy=0, done=1, pass=(err_count==0); w,x,y,z hold 4'hF; results held until next start or reset.
- start while busy: ignored. start and abort together in IDLE/DONE: start accepted.
- abort in SETTLE/SAMPLE: -> IDLE next edge; idx and w,x,y,z <=0; busy=0, done=0, pass=0; err_count/fail_mask/first_fail_* keep partial values (not qualified by done). abort in IDLE/DONE: ignored.
- rst mid-sweep: all state cleared immediately per reset values; no completion reported.
- r6..r9 are sampled only in SAMPLE; values in other states are don't-care.

Test Plan:
- Correct breadboard model, start pulse -> busy for 48 cycles, done=1, pass=1, err_count=0, fail_mask=4'b0000, first_fail_valid=0.
- r8 stuck at 0 -> done, pass=0, err_count=4, fail_mask=4'b0100, first_fail_idx=3.
- r9 inverted -> err_count=16 (5'b10000), fail_mask=4'b1000, first_fail_idx=0; also r6 stuck at 1 combined -> err_count=16, fail_mask=4'b1001.
- Check drive timing: each {w,x,y,z} value 0..15 held exactly 3 cycles (default), sequence ends at 4'hF with no wrap to 0; rerun with SETTLE_CYCLES=1 -> 32-cycle sweep.
- abort when idx=7 -> next cycle busy=0, done=0, wxyz=0; start while busy at idx=4 ignored; start in DONE restarts and clears done/err_count.
- rst asserted mid-SETTLE at idx=9 -> outputs zero asynchronously before next clk edge; subsequent start completes a clean sweep with pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Self-checking sweeper for the 4-input breadboard logic block: drives all 16
// input vectors, waits a settle time, samples r6..r9 and compares to golden.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP6          = 16'h212E,
    parameter logic [15:0] EXP7          = 16'h1668,
    parameter logic [15:0] EXP8          = 16'h8888,
    parameter logic [15:0] EXP9          = 16'h6996
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       r6,
    input  logic       r7,
    input  logic       r8,
    input  logic       r9,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_mask,
    output logic [3:0] first_fail_idx,
    output logic       first_fail_valid
);

    // state  | meaning
    // IDLE   | waiting for start, outputs cleared
    // SETTLE | holding current vector while settle counter runs down
    // SAMPLE | one cycle: compare r6..r9 against golden, advance or finish
    // DONE   | sweep complete, results held until next start
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] idx_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [4:0] err_q;
    logic [3:0] mask_q;
    logic [3:0] ffi_q;
    logic       ffv_q;

    logic [3:0] exp_vec;
    logic [3:0] mism;
    logic [4:0] err_d;
    logic [3:0] mask_d;

    assign exp_vec = {EXP9[idx_q], EXP8[idx_q], EXP7[idx_q], EXP6[idx_q]};
    assign mism    = {r9, r8, r7, r6} ^ exp_vec;
    assign err_d   = err_q + {4'b0000, |mism};
    assign mask_d  = mask_q | mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'h0;
            cnt_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            mask_q  <= 4'h0;
            ffi_q   <= 4'h0;
            ffv_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        idx_q   <= 4'h0;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 5'd0;
                        mask_q  <= 4'h0;
                        ffi_q   <= 4'h0;
                        ffv_q   <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        idx_q   <= 4'h0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (cnt_q == 4'h0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                SAMPLE: begin
                    // abort wins over the sample: the pending vector is not scored
                    if (abort) begin
                        state_q <= IDLE;
                        idx_q   <= 4'h0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        if (mism != 4'h0) begin
                            err_q  <= err_d;
                            mask_q <= mask_d;
                            if (!ffv_q) begin
                                ffi_q <= idx_q;
                                ffv_q <= 1'b1;
                            end
                        end
                        if (idx_q == 4'hF) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 5'd0);
                        end else begin
                            state_q <= SETTLE;
                            idx_q   <= idx_q + 4'h1;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {w, x, y, z}     = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign fail_mask        = mask_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: breadboard model with injectable faults, a
// per-cycle reference model, and directed checks with hand-computed results.
module tb_truth_table_sweeper;

    localparam logic [15:0] EXP6 = 16'h212E;
    localparam logic [15:0] EXP7 = 16'h1668;
    localparam logic [15:0] EXP8 = 16'h8888;
    localparam logic [15:0] EXP9 = 16'h6996;
    localparam int          P    = 3;          // default SETTLE_CYCLES + 1

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start_b = 1'b0;
    int   fault = 0;

    logic       w, x, y, z, r6, r7, r8, r9;
    logic       busy, done, pass, first_fail_valid;
    logic [4:0] err_count;
    logic [3:0] fail_mask, first_fail_idx;

    logic       wb, xb, yb, zb, r6b, r7b, r8b, r9b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [4:0] err_b;
    logic [3:0] mask_b, ffi_b;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [3:0] gold(input int i);
        gold = {EXP9[i], EXP8[i], EXP7[i], EXP6[i]};
    endfunction

    // breadboard: returns {r9,r8,r7,r6}
    function automatic logic [3:0] bb(input int i, input int f);
        logic [3:0] v;
        v = gold(i);
        case (f)
            1: v[2] = 1'b0;
            2: v[3] = ~v[3];
            3: begin v[3] = ~v[3]; v[0] = 1'b1; end
            default: ;
        endcase
        bb = v;
    endfunction

    assign {r9, r8, r7, r6}     = bb(int'({w, x, y, z}), fault);
    assign {r9b, r8b, r7b, r6b} = bb(int'({wb, xb, yb, zb}), 0);

    truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .w(w), .x(x), .y(y), .z(z),
        .r6(r6), .r7(r7), .r8(r8), .r9(r9),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_fail_idx(first_fail_idx),
        .first_fail_valid(first_fail_valid)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .w(wb), .x(xb), .y(yb), .z(zb),
        .r6(r6b), .r7(r7b), .r8(r8b), .r9(r9b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_mask(mask_b), .first_fail_idx(ffi_b),
        .first_fail_valid(ffv_b)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: progress counted as elapsed cycles since start accept;
    // vector index is cycles/P and the sample falls on the last cycle of each P.
    bit         m_run, m_done, m_pass, m_ffv;
    int         m_cyc, m_err, m_ffi;
    logic [3:0] m_mask;
    logic [3:0] m_mism;
    assign m_mism = {r9, r8, r7, r6} ^ gold(m_cyc / P);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_done <= 0; m_pass <= 0; m_ffv <= 0;
            m_cyc <= 0; m_err <= 0; m_ffi <= 0; m_mask <= 4'h0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1; m_done <= 0; m_pass <= 0; m_ffv <= 0;
                m_cyc <= 0; m_err <= 0; m_ffi <= 0; m_mask <= 4'h0;
            end
        end else if (abort) begin
            m_run <= 0; m_done <= 0; m_pass <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc % P == P - 1) begin
                if (m_mism != 4'h0) begin
                    m_err  <= m_err + 1;
                    m_mask <= m_mask | m_mism;
                    if (!m_ffv) begin
                        m_ffv <= 1;
                        m_ffi <= m_cyc / P;
                    end
                end
                if (m_cyc / P == 15) begin
                    m_run  <= 0;
                    m_done <= 1;
                    m_pass <= (m_err + ((m_mism != 4'h0) ? 1 : 0)) == 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("m_busy", int'(busy), int'(m_run));
            check("m_done", int'(done), int'(m_done));
            check("m_pass", int'(pass), int'(m_pass));
            check("m_wxyz", int'({w, x, y, z}), m_run ? m_cyc / P : (m_done ? 15 : 0));
            check("m_err", int'(err_count), m_err);
            check("m_mask", int'(fail_mask), int'(m_mask));
            check("m_ffv", int'(first_fail_valid), int'(m_ffv));
            check("m_ffi", int'(first_fail_idx), m_ffi);
        end
    end

    task automatic run_sweep(input int poke, output int n);
        int  g;
        bit  poked;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0; g = 0; poked = 0;
        while (!done && g < 300) begin
            start = 1'b0;
            if (poke >= 0 && !poked && busy && int'({w, x, y, z}) == poke) begin
                start = 1'b1;
                poked = 1;
            end
            if (busy) n++;
            g++;
            @(negedge clk);
        end
        start = 1'b0;
        if (g >= 300) check("sweep_timeout", g, 0);
        check("end_wxyz", int'({w, x, y, z}), 15);
    endtask

    task automatic wait_idx(input int v);
        int g = 0;
        while (int'({w, x, y, z}) != v && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("wait_idx_timeout", g, 0);
    endtask

    task automatic check_results(input string tag, input int p, input int e,
                                 input int m, input int fv, input int fi);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_pass"}, int'(pass), p);
        check({tag, "_err"}, int'(err_count), e);
        check({tag, "_mask"}, int'(fail_mask), m);
        check({tag, "_ffv"}, int'(first_fail_valid), fv);
        if (fv != 0) check({tag, "_ffi"}, int'(first_fail_idx), fi);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wxyz", int'({w, x, y, z}), 0);
        check("rst_err", int'(err_count), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // clean sweep: 48 busy cycles, each vector held 3 cycles, pass
        fault = 0;
        run_sweep(-1, n);
        check("clean_cycles", n, 48);
        check_results("clean", 1, 0, 0, 0, 0);

        // r8 stuck at 0: fails where y&z, i.e. idx 3,7,11,15
        fault = 1;
        run_sweep(-1, n);
        check_results("r8s0", 0, 4, 4'b0100, 1, 3);

        fault = 2;
        run_sweep(-1, n);
        check_results("r9inv", 0, 16, 4'b1000, 1, 0);

        fault = 3;
        run_sweep(-1, n);
        check_results("r9inv_r6s1", 0, 16, 4'b1001, 1, 0);

        // start while busy at idx 4 must not restart the sweep
        fault = 0;
        run_sweep(4, n);
        check("busy_start_cycles", n, 48);
        check_results("busy_start", 1, 0, 0, 0, 0);

        // abort at idx 7 with r8 fault: partial results kept (idx 3 failed)
        fault = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("restart_done_clr", int'(done), 0);
        check("restart_err_clr", int'(err_count), 0);
        wait_idx(7);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_wxyz", int'({w, x, y, z}), 0);
        check("abort_err", int'(err_count), 1);
        check("abort_ffi", int'(first_fail_idx), 3);
        repeat (3) @(negedge clk);

        // async reset mid-settle at idx 9
        fault = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idx(9);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_wxyz", int'({w, x, y, z}), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_sweep(-1, n);
        check("post_rst_cycles", n, 48);
        check_results("post_rst", 1, 0, 0, 0, 0);

        // SETTLE_CYCLES=1 instance: 2 cycles per vector, 32 total
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        n = 0;
        for (int g = 0; g < 200 && !done_b; g++) begin
            if (busy_b) n++;
            @(negedge clk);
        end
        check("b_cycles", n, 32);
        check("b_done", int'(done_b), 1);
        check("b_pass", int'(pass_b), 1);
        check("b_wxyz", int'({wb, xb, yb, zb}), 15);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
